// File: rtl/sha256_seq_pkg.sv
// Shared types, sizes and block-manipulation helpers for the SHA-256 message sequencer.
package sha256_seq_pkg;

  localparam int SHA256_BLOCK_BITS = 512;
  localparam int SHA256_HASH_BITS  = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_PAD   = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_P80  = 2'd1,
    PEND_LEN  = 2'd2
  } pad_pend_e;

  // Byte 0 of a block sits in the most significant byte lane.
  function automatic logic [SHA256_BLOCK_BITS-1:0] put_byte(
    input logic [SHA256_BLOCK_BITS-1:0] blk,
    input logic [5:0]                   idx,
    input logic [7:0]                   val
  );
    logic [SHA256_BLOCK_BITS-1:0] blk_v;
    blk_v = blk;
    for (int i = 0; i < 64; i++) begin
      if (6'(i) == idx) begin
        blk_v[511-8*i -: 8] = val;
      end
    end
    return blk_v;
  endfunction

  // Keeps bytes below idx, writes 0x80 (or 0x00) at idx, zeroes the rest and
  // optionally overlays the 64-bit big-endian bit length in bytes 56..63.
  function automatic logic [SHA256_BLOCK_BITS-1:0] pad_block(
    input logic [SHA256_BLOCK_BITS-1:0] blk,
    input logic [6:0]                   idx,
    input logic [63:0]                  bitlen,
    input logic                         put80,
    input logic                         putlen
  );
    logic [SHA256_BLOCK_BITS-1:0] blk_v;
    blk_v = blk;
    for (int i = 0; i < 64; i++) begin
      if (7'(i) == idx) begin
        blk_v[511-8*i -: 8] = put80 ? 8'h80 : 8'h00;
      end else if (7'(i) > idx) begin
        blk_v[511-8*i -: 8] = 8'h00;
      end
    end
    if (putlen) begin
      blk_v[63:0] = bitlen;
    end
    return blk_v;
  endfunction

endpackage

// File: rtl/sha256_msg_sequencer.sv
// Byte-stream front end for a SHA-256 core: assembles and pads 512-bit blocks,
// sequences the core's init/next/ready handshake and captures the final digest.
module sha256_msg_sequencer
  import sha256_seq_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         msg_valid_i,
  output logic                         msg_ready_o,
  input  logic [7:0]                   msg_byte_i,
  input  logic                         msg_last_i,
  input  logic                         msg_empty_i,
  output logic                         core_init_o,
  output logic                         core_next_o,
  output logic [SHA256_BLOCK_BITS-1:0] core_block_o,
  input  logic                         core_ready_i,
  input  logic [SHA256_HASH_BITS-1:0]  core_digest_i,
  input  logic                         core_digest_valid_i,
  output logic [SHA256_HASH_BITS-1:0]  digest_o,
  output logic                         digest_valid_o,
  output logic                         busy_o
);

  seq_state_e                   r_state;
  pad_pend_e                    r_pend;
  logic [SHA256_BLOCK_BITS-1:0] r_block;
  logic [6:0]                   r_idx;
  logic [LEN_W-1:0]             r_bytecnt;
  logic                         r_final;
  logic                         r_first;
  logic                         r_wait_first;
  logic                         r_msg_ready;
  logic                         r_init;
  logic                         r_next;
  logic [SHA256_HASH_BITS-1:0]  r_digest;
  logic                         r_digest_valid;
  logic                         r_busy;

  logic                         w_accept;
  logic                         w_empty_last;
  logic [63:0]                  w_bitlen;

  assign w_accept     = msg_valid_i & r_msg_ready;
  assign w_empty_last = msg_last_i & msg_empty_i;
  assign w_bitlen     = 64'({r_bytecnt, 3'b000});

  // Sequencer FSM: byte capture, padding, core handshake and digest capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= ST_IDLE;
      r_pend         <= PEND_NONE;
      r_block        <= '0;
      r_idx          <= 7'd0;
      r_bytecnt      <= '0;
      r_final        <= 1'b0;
      r_first        <= 1'b0;
      r_wait_first   <= 1'b0;
      r_msg_ready    <= 1'b0;
      r_init         <= 1'b0;
      r_next         <= 1'b0;
      r_digest       <= '0;
      r_digest_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_init <= 1'b0;
      r_next <= 1'b0;
      case (r_state)
        ST_IDLE, ST_FILL: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            if (r_state == ST_IDLE) begin
              r_first        <= 1'b1;
              r_digest_valid <= 1'b0;
            end
            if (w_empty_last) begin
              r_state     <= ST_PAD;
              r_msg_ready <= 1'b0;
            end else begin
              r_block   <= put_byte(r_block, r_idx[5:0], msg_byte_i);
              r_idx     <= r_idx + 7'd1;
              r_bytecnt <= r_bytecnt + LEN_W'(1);
              if (msg_last_i) begin
                r_state     <= ST_PAD;
                r_msg_ready <= 1'b0;
              end else if (r_idx == 7'd63) begin
                r_state     <= ST_ISSUE;
                r_msg_ready <= 1'b0;
                r_final     <= 1'b0;
                r_pend      <= PEND_NONE;
              end else begin
                r_state     <= ST_FILL;
                r_msg_ready <= 1'b1;
              end
            end
          end else begin
            r_msg_ready <= 1'b1;
          end
        end

        ST_PAD: begin
          r_state <= ST_ISSUE;
          if (r_idx == 7'd64) begin
            r_final <= 1'b0;
            r_pend  <= PEND_P80;
          end else if (r_idx <= 7'd55) begin
            r_block <= pad_block(r_block, r_idx, w_bitlen, 1'b1, 1'b1);
            r_final <= 1'b1;
            r_pend  <= PEND_NONE;
          end else begin
            r_block <= pad_block(r_block, r_idx, w_bitlen, 1'b1, 1'b0);
            r_final <= 1'b0;
            r_pend  <= PEND_LEN;
          end
        end

        ST_ISSUE: begin
          if (core_ready_i) begin
            r_init       <= r_first;
            r_next       <= ~r_first;
            r_first      <= 1'b0;
            r_wait_first <= 1'b1;
            r_state      <= ST_WAIT;
          end else begin
            r_state <= ST_ISSUE;
          end
        end

        // The first WAIT cycle overlaps the registered pulse, so the core's ready is stale there.
        ST_WAIT: begin
          if (r_wait_first) begin
            r_wait_first <= 1'b0;
          end else if (core_ready_i && (!r_final || core_digest_valid_i)) begin
            if (r_final) begin
              r_digest       <= core_digest_i;
              r_digest_valid <= 1'b1;
              r_block        <= '0;
              r_idx          <= 7'd0;
              r_bytecnt      <= '0;
              r_final        <= 1'b0;
              r_state        <= ST_IDLE;
              r_msg_ready    <= 1'b1;
              r_busy         <= 1'b0;
            end else begin
              case (r_pend)
                PEND_P80: begin
                  r_block <= pad_block('0, 7'd0, w_bitlen, 1'b1, 1'b1);
                  r_final <= 1'b1;
                  r_pend  <= PEND_NONE;
                  r_state <= ST_ISSUE;
                end
                PEND_LEN: begin
                  r_block <= pad_block('0, 7'd0, w_bitlen, 1'b0, 1'b1);
                  r_final <= 1'b1;
                  r_pend  <= PEND_NONE;
                  r_state <= ST_ISSUE;
                end
                default: begin
                  r_block     <= '0;
                  r_idx       <= 7'd0;
                  r_state     <= ST_FILL;
                  r_msg_ready <= 1'b1;
                end
              endcase
            end
          end else begin
            r_state <= ST_WAIT;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_msg_ready <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign msg_ready_o    = r_msg_ready;
  assign core_init_o    = r_init;
  assign core_next_o    = r_next;
  assign core_block_o   = r_block;
  assign digest_o       = r_digest;
  assign digest_valid_o = r_digest_valid;
  assign busy_o         = r_busy;

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Scoreboard bench for sha256_msg_sequencer with a behavioural SHA-256 core model.
`timescale 1ns/1ps
module tb_sha256_msg_sequencer;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         msg_valid_i, msg_ready_o, msg_last_i, msg_empty_i;
  logic [7:0]   msg_byte_i;
  logic         core_init_o, core_next_o, core_ready_i, core_digest_valid_i;
  logic [511:0] core_block_o;
  logic [255:0] core_digest_i, digest_o;
  logic         digest_valid_o, busy_o;

  always #5 clk = ~clk;

  sha256_msg_sequencer #(.LEN_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o), .msg_byte_i(msg_byte_i),
    .msg_last_i(msg_last_i), .msg_empty_i(msg_empty_i),
    .core_init_o(core_init_o), .core_next_o(core_next_o), .core_block_o(core_block_o),
    .core_ready_i(core_ready_i), .core_digest_i(core_digest_i),
    .core_digest_valid_i(core_digest_valid_i),
    .digest_o(digest_o), .digest_valid_o(digest_valid_o), .busy_o(busy_o)
  );

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [255:0] DIG_ABC   = 256'hBA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD;
  localparam logic [255:0] DIG_EMPTY = 256'hE3B0C44298FC1C149AFBF4C8996FB92427AE41E4649B934CA495991B7852B855;
  localparam logic [255:0] DIG_56    = 256'h248D6A61D20638B8E5C026930C3E6039A33CE45964FF2167F6ECEDD419DB06C1;
  localparam logic [255:0] DIG_A     = 256'hCA978112CA1BBDCAFAC231B39A23DC4DA786EFF8147C4E72B9807785AFEE48BB;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  int n_chk = 0;
  int n_fail = 0;
  int init_cnt = 0;
  int next_cnt = 0;
  logic [511:0] exp_blk_q[$];
  logic         exp_init_q[$];
  logic [255:0] exp_dig_q[$];
  logic [7:0]   msg_q[$];

  int           core_lat = 4;
  logic         hold_ready = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural core: latches the block on init/next, answers after core_lat cycles.
  initial begin
    int cnt;
    logic [255:0] h;
    logic [511:0] blk;
    logic is_init;
    cnt = 0; h = '0; blk = '0; is_init = 1'b0;
    core_ready_i = 1'b1; core_digest_valid_i = 1'b0; core_digest_i = '0;
    forever begin
      @(negedge clk);
      if (core_init_o || core_next_o) begin
        blk = core_block_o; is_init = core_init_o;
        core_ready_i = 1'b0; core_digest_valid_i = 1'b0; cnt = core_lat;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          h = sha_compress(is_init ? IV : h, blk);
          core_digest_i = h; core_digest_valid_i = 1'b1; core_ready_i = !hold_ready;
        end
      end else begin
        core_ready_i = !hold_ready;
      end
    end
  end

  // Monitor: pops the scoreboard on every block pulse and on each new digest.
  initial begin
    logic dv_prev;
    logic [511:0] eb;
    logic ei;
    dv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (core_init_o || core_next_o) begin
        if (core_init_o) init_cnt++;
        if (core_next_o) next_cnt++;
        check("init_next_exclusive", 512'(core_init_o & core_next_o), 512'(0));
        if (exp_blk_q.size() == 0) begin
          check("unexpected_block", 512'(exp_blk_q.size()), 512'(1));
        end else begin
          eb = exp_blk_q.pop_front();
          ei = exp_init_q.pop_front();
          check("block_bytes", core_block_o, eb);
          check("block_is_init", 512'(core_init_o), 512'(ei));
        end
      end
      if (digest_valid_o && !dv_prev) begin
        if (exp_dig_q.size() == 0) begin
          check("unexpected_digest", 512'(exp_dig_q.size()), 512'(1));
        end else begin
          check("digest", 512'(digest_o), 512'(exp_dig_q.pop_front()));
        end
      end
      dv_prev = digest_valid_o;
    end
  end

  task automatic load_str(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
  endtask

  task automatic load_pat(input int n, input int seed);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'((i * 37 + seed) & 255));
  endtask

  // Reference padding: message, 0x80, zero fill, 64-bit big-endian bit length.
  task automatic expect_msg(input logic use_const, input logic [255:0] dig_const);
    int n;
    int nblk;
    logic [7:0] pb[$];
    logic [511:0] blk;
    logic [255:0] h;
    logic [63:0] bl;
    n = msg_q.size();
    nblk = (n + 72) / 64;
    bl = 64'(n) * 64'd8;
    h = IV;
    for (int i = 0; i < n; i++) pb.push_back(msg_q[i]);
    pb.push_back(8'h80);
    while (pb.size() < nblk * 64 - 8) pb.push_back(8'h00);
    for (int i = 0; i < 8; i++) pb.push_back(bl[63-8*i -: 8]);
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = pb[b*64+i];
      exp_blk_q.push_back(blk);
      exp_init_q.push_back(b == 0);
      h = sha_compress(h, blk);
    end
    exp_dig_q.push_back(use_const ? dig_const : h);
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    while (!msg_ready_o && g < 500) begin
      msg_valid_i = 1'b0;
      @(negedge clk);
      g++;
    end
    if (g >= 500) check("msg_ready_timeout", 512'(msg_ready_o), 512'(1));
  endtask

  task automatic send_msg(input logic empty);
    int total;
    total = empty ? 1 : msg_q.size();
    for (int i = 0; i < total; i++) begin
      wait_ready();
      msg_valid_i = 1'b1;
      msg_byte_i  = empty ? 8'hA5 : msg_q[i];
      msg_last_i  = (i == total - 1);
      msg_empty_i = empty;
      @(negedge clk);
    end
    msg_valid_i = 1'b0; msg_last_i = 1'b0; msg_empty_i = 1'b0; msg_byte_i = 8'h00;
  endtask

  task automatic wait_done(input string name);
    int g;
    g = 0;
    while (!(digest_valid_o && !busy_o) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check({name, "_done"}, 512'(digest_valid_o), 512'(1));
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_msg_ready"}, 512'(msg_ready_o), 512'(0));
    check({name, "_init"}, 512'(core_init_o), 512'(0));
    check({name, "_next"}, 512'(core_next_o), 512'(0));
    check({name, "_block"}, core_block_o, 512'(0));
    check({name, "_digest"}, 512'(digest_o), 512'(0));
    check({name, "_digest_valid"}, 512'(digest_valid_o), 512'(0));
    check({name, "_busy"}, 512'(busy_o), 512'(0));
  endtask

  initial begin
    int i0, n0, p0, g;
    logic [511:0] bp_blk;
    rst_ni = 1'b0; msg_valid_i = 1'b0; msg_byte_i = 8'h00; msg_last_i = 1'b0; msg_empty_i = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_ni = 1'b1;
    @(negedge clk);

    i0 = init_cnt; n0 = next_cnt;
    load_str("abc"); expect_msg(1'b1, DIG_ABC); send_msg(1'b0); wait_done("abc");
    check("abc_inits", 512'(init_cnt - i0), 512'(1));
    check("abc_nexts", 512'(next_cnt - n0), 512'(0));

    i0 = init_cnt; n0 = next_cnt;
    msg_q.delete(); expect_msg(1'b1, DIG_EMPTY); send_msg(1'b1); wait_done("empty");
    check("empty_inits", 512'(init_cnt - i0), 512'(1));
    check("empty_nexts", 512'(next_cnt - n0), 512'(0));

    i0 = init_cnt; n0 = next_cnt;
    load_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    expect_msg(1'b1, DIG_56); send_msg(1'b0); wait_done("len56");
    check("len56_inits", 512'(init_cnt - i0), 512'(1));
    check("len56_nexts", 512'(next_cnt - n0), 512'(1));

    i0 = init_cnt; n0 = next_cnt;
    load_pat(64, 11); expect_msg(1'b0, '0); send_msg(1'b0); wait_done("len64");
    check("len64_nexts", 512'(next_cnt - n0), 512'(1));

    i0 = init_cnt; n0 = next_cnt;
    load_pat(55, 200); expect_msg(1'b0, '0); send_msg(1'b0); wait_done("len55");
    check("len55_blocks", 512'(init_cnt - i0 + next_cnt - n0), 512'(1));

    // Backpressure: core held busy while the block waits in ISSUE.
    hold_ready = 1'b1;
    load_str("abc"); expect_msg(1'b1, DIG_ABC);
    bp_blk = exp_blk_q[0];
    send_msg(1'b0);
    repeat (2) @(negedge clk);
    p0 = init_cnt + next_cnt;
    for (int c = 0; c < 20; c++) begin
      check("bp_no_pulse", 512'(core_init_o | core_next_o), 512'(0));
      check("bp_msg_ready", 512'(msg_ready_o), 512'(0));
      check("bp_block_stable", core_block_o, bp_blk);
      @(negedge clk);
    end
    hold_ready = 1'b0;
    repeat (6) @(negedge clk);
    check("bp_single_pulse", 512'(init_cnt + next_cnt - p0), 512'(1));
    wait_done("bp");

    // Reset while the core is still working on the block.
    core_lat = 40;
    p0 = init_cnt;
    load_str("abc"); expect_msg(1'b1, DIG_ABC); send_msg(1'b0);
    g = 0;
    while (init_cnt == p0 && g < 200) begin @(negedge clk); g++; end
    check("rst_reached_wait", 512'(init_cnt - p0), 512'(1));
    repeat (3) @(negedge clk);
    rst_ni = 1'b0;
    #1;
    check_all_zero("rst_wait");
    exp_dig_q.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    core_lat = 4;
    g = 0;
    while (!core_ready_i && g < 200) begin @(negedge clk); g++; end
    i0 = init_cnt;
    load_str("a"); expect_msg(1'b1, DIG_A); send_msg(1'b0); wait_done("after_rst");
    check("after_rst_init", 512'(init_cnt - i0), 512'(1));

    check("blk_queue_drained", 512'(exp_blk_q.size()), 512'(0));
    check("dig_queue_drained", 512'(exp_dig_q.size()), 512'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
